// File: rtl/glitch_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// glitch_sweep_ctrl
//
// Campaign sequencer for the glitch generator. Walks a (delay, width) grid
// with delay as the outer loop and width as the inner loop. Each grid point
// is attempted REPEATS times. One attempt is:
//   program engine -> arm -> wait for done -> settle -> sample target_fault.
// The campaign stops early when the target reports a fault (hit), or with
// err set if the engine never answers within TIMEOUT cycles.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    1-cycle pulse, begins a campaign from IDLE/DONE/ERR
//   abort                    level, forces IDLE on the next cycle (beats start)
//   delay_start/step/count   outer sweep: first value, increment, number of points
//   width_start/step/count   inner sweep: first value, increment, number of points
//   eng_delay, eng_width     configuration presented to the glitch engine
//   eng_arm                  1-cycle pulse, engine starts one attempt
//   eng_done                 1-cycle pulse from engine, glitch emitted
//   target_fault             synchronised target status, 1 = fault observed
//   busy                     campaign in progress
//   hit, hit_delay, hit_width campaign stopped on a fault at this point
//   err                      campaign stopped on engine timeout
//   attempts                 attempts completed this campaign (saturating)
//   dbg_state                current FSM state, for checkers and debug
//
// Engine handshake: eng_arm is high for exactly one cycle per attempt, and
// eng_delay/eng_width are stable from that cycle until the attempt has been
// sampled. The engine answers with a single-cycle eng_done at any time after
// the arm cycle; a done coinciding with the arm cycle itself is not seen.
// ---------------------------------------------------------------------------
module glitch_sweep_ctrl #(
    parameter int unsigned DW      = 32,
    parameter int unsigned WW      = 16,
    parameter int unsigned REPEATS = 4,
    parameter int unsigned SETTLE  = 1200,
    parameter int unsigned TIMEOUT = 24000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] delay_start,
    input  logic [DW-1:0] delay_step,
    input  logic [15:0]   delay_count,
    input  logic [WW-1:0] width_start,
    input  logic [WW-1:0] width_step,
    input  logic [15:0]   width_count,
    output logic [DW-1:0] eng_delay,
    output logic [WW-1:0] eng_width,
    output logic          eng_arm,
    input  logic          eng_done,
    input  logic          target_fault,
    output logic          busy,
    output logic          hit,
    output logic          err,
    output logic [DW-1:0] hit_delay,
    output logic [WW-1:0] hit_width,
    output logic [31:0]   attempts,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ARM    = 3'd2,
        S_WAIT   = 3'd3,
        S_SETTLE = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t        state_q, state_d;

    // Campaign configuration, captured on start so the host may change its
    // registers while a sweep is running.
    logic [DW-1:0] ds_q, ds_d;
    logic [DW-1:0] dstep_q, dstep_d;
    logic [15:0]   dc_q, dc_d;
    logic [WW-1:0] ws_q, ws_d;
    logic [WW-1:0] wstep_q, wstep_d;
    logic [15:0]   wc_q, wc_d;

    logic [DW-1:0] eng_delay_q, eng_delay_d;
    logic [WW-1:0] eng_width_q, eng_width_d;
    logic [15:0]   d_idx_q, d_idx_d;
    logic [15:0]   w_idx_q, w_idx_d;
    logic [31:0]   r_idx_q, r_idx_d;

    // Shared cycle counter: timeout window in ARM/WAIT, settle time in SETTLE.
    logic [31:0]   ctr_q, ctr_d;

    logic          hit_q, hit_d;
    logic          err_q, err_d;
    logic [DW-1:0] hit_delay_q, hit_delay_d;
    logic [WW-1:0] hit_width_q, hit_width_d;
    logic [31:0]   attempts_q, attempts_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ds_q        <= '0;
            dstep_q     <= '0;
            dc_q        <= '0;
            ws_q        <= '0;
            wstep_q     <= '0;
            wc_q        <= '0;
            eng_delay_q <= '0;
            eng_width_q <= '0;
            d_idx_q     <= '0;
            w_idx_q     <= '0;
            r_idx_q     <= '0;
            ctr_q       <= '0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            hit_delay_q <= '0;
            hit_width_q <= '0;
            attempts_q  <= '0;
        end else begin
            state_q     <= state_d;
            ds_q        <= ds_d;
            dstep_q     <= dstep_d;
            dc_q        <= dc_d;
            ws_q        <= ws_d;
            wstep_q     <= wstep_d;
            wc_q        <= wc_d;
            eng_delay_q <= eng_delay_d;
            eng_width_q <= eng_width_d;
            d_idx_q     <= d_idx_d;
            w_idx_q     <= w_idx_d;
            r_idx_q     <= r_idx_d;
            ctr_q       <= ctr_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
            hit_delay_q <= hit_delay_d;
            hit_width_q <= hit_width_d;
            attempts_q  <= attempts_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ds_d        = ds_q;
        dstep_d     = dstep_q;
        dc_d        = dc_q;
        ws_d        = ws_q;
        wstep_d     = wstep_q;
        wc_d        = wc_q;
        eng_delay_d = eng_delay_q;
        eng_width_d = eng_width_q;
        d_idx_d     = d_idx_q;
        w_idx_d     = w_idx_q;
        r_idx_d     = r_idx_q;
        ctr_d       = ctr_q;
        hit_d       = hit_q;
        err_d       = err_q;
        hit_delay_d = hit_delay_q;
        hit_width_d = hit_width_q;
        attempts_d  = attempts_q;

        if (abort) begin
            state_d = S_IDLE;
            hit_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        ds_d       = delay_start;
                        dstep_d    = delay_step;
                        dc_d       = delay_count;
                        ws_d       = width_start;
                        wstep_d    = width_step;
                        wc_d       = width_count;
                        hit_d      = 1'b0;
                        err_d      = 1'b0;
                        attempts_d = '0;
                        state_d    = S_LOAD;
                    end
                end

                S_LOAD: begin
                    eng_delay_d = ds_q;
                    eng_width_d = ws_q;
                    d_idx_d     = '0;
                    w_idx_d     = '0;
                    r_idx_d     = '0;
                    if (dc_q == 16'd0 || wc_q == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ARM;
                    end
                end

                S_ARM: begin
                    // The arm cycle is the first cycle of the timeout window,
                    // so err rises exactly TIMEOUT cycles after eng_arm.
                    ctr_d   = 32'd1;
                    state_d = S_WAIT;
                end

                S_WAIT: begin
                    if (eng_done) begin
                        ctr_d   = '0;
                        state_d = S_SETTLE;
                    end else if (ctr_q >= TIMEOUT - 1) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        ctr_d = ctr_q + 32'd1;
                    end
                end

                S_SETTLE: begin
                    if (ctr_q == SETTLE - 1) begin
                        if (attempts_q != '1) begin
                            attempts_d = attempts_q + 32'd1;
                        end
                        if (target_fault) begin
                            hit_d       = 1'b1;
                            hit_delay_d = eng_delay_q;
                            hit_width_d = eng_width_q;
                            state_d     = S_DONE;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end else begin
                        ctr_d = ctr_q + 32'd1;
                    end
                end

                S_NEXT: begin
                    // Repeat index wraps first, then width, then delay; the
                    // last delay point ends the campaign instead of re-arming.
                    state_d = S_ARM;
                    if (r_idx_q == REPEATS - 1) begin
                        r_idx_d = '0;
                        if (w_idx_q == wc_q - 16'd1) begin
                            w_idx_d     = '0;
                            eng_width_d = ws_q;
                            if (d_idx_q == dc_q - 16'd1) begin
                                state_d = S_DONE;
                            end else begin
                                d_idx_d     = d_idx_q + 16'd1;
                                eng_delay_d = eng_delay_q + dstep_q;
                            end
                        end else begin
                            w_idx_d     = w_idx_q + 16'd1;
                            eng_width_d = eng_width_q + wstep_q;
                        end
                    end else begin
                        r_idx_d = r_idx_q + 32'd1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign eng_delay = eng_delay_q;
    assign eng_width = eng_width_q;
    assign eng_arm   = (state_q == S_ARM);
    assign busy      = (state_q == S_LOAD) || (state_q == S_ARM) || (state_q == S_WAIT) ||
                       (state_q == S_SETTLE) || (state_q == S_NEXT);
    assign hit       = hit_q;
    assign err       = err_q;
    assign hit_delay = hit_delay_q;
    assign hit_width = hit_width_q;
    assign attempts  = attempts_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_glitch_sweep_ctrl
//
// Directed and randomized campaigns against glitch_sweep_ctrl. The reference
// model is the grid itself: a queue of (delay, width) points built with plain
// nested loops and modular arithmetic, consumed one entry per eng_arm. A small
// engine model answers each arm with eng_done after a chosen latency, and
// raises target_fault for a chosen attempt number.
// ---------------------------------------------------------------------------
module tb_glitch_sweep_ctrl;

    localparam int DW      = 32;
    localparam int WW      = 16;
    localparam int REPEATS = 2;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 50;
    localparam int BUDGET  = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] delay_start;
    logic [DW-1:0] delay_step;
    logic [15:0]   delay_count;
    logic [WW-1:0] width_start;
    logic [WW-1:0] width_step;
    logic [15:0]   width_count;
    logic [DW-1:0] eng_delay;
    logic [WW-1:0] eng_width;
    logic          eng_arm;
    logic          eng_done;
    logic          target_fault;
    logic          busy;
    logic          hit;
    logic          err;
    logic [DW-1:0] hit_delay;
    logic [WW-1:0] hit_width;
    logic [31:0]   attempts;
    logic [2:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    // Full attempt plan of the current campaign, and the scoreboard copy that
    // each observed arm pops from.
    logic [DW+WW-1:0] plan[$];
    logic [DW+WW-1:0] exp_q[$];

    always #5 clk = ~clk;

    glitch_sweep_ctrl #(
        .DW      (DW),
        .WW      (WW),
        .REPEATS (REPEATS),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .delay_start  (delay_start),
        .delay_step   (delay_step),
        .delay_count  (delay_count),
        .width_start  (width_start),
        .width_step   (width_step),
        .width_count  (width_count),
        .eng_delay    (eng_delay),
        .eng_width    (eng_width),
        .eng_arm      (eng_arm),
        .eng_done     (eng_done),
        .target_fault (target_fault),
        .busy         (busy),
        .hit          (hit),
        .err          (err),
        .hit_delay    (hit_delay),
        .hit_width    (hit_width),
        .attempts     (attempts),
        .dbg_state    (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_cfg(input logic [DW-1:0] ds, input logic [DW-1:0] dst, input logic [15:0] dc,
                           input logic [WW-1:0] ws, input logic [WW-1:0] wst, input logic [15:0] wc);
        logic [DW-1:0] dv;
        logic [WW-1:0] wv;
        delay_start = ds;
        delay_step  = dst;
        delay_count = dc;
        width_start = ws;
        width_step  = wst;
        width_count = wc;
        plan.delete();
        for (int d = 0; d < int'(dc); d++) begin
            for (int w = 0; w < int'(wc); w++) begin
                for (int r = 0; r < REPEATS; r++) begin
                    dv = ds + dst * DW'(d);
                    wv = ws + wst * WW'(w);
                    plan.push_back({dv, wv});
                end
            end
        end
        exp_q = plan;
    endtask

    // Runs one campaign cycle by cycle, acting as engine and target.
    //   fault_at   attempt number whose sample sees target_fault=1 (0 = never)
    //   lat        arm-to-done latency in cycles (0 = random 1..6)
    //   respond    0 = engine never answers
    //   abort_arm  attempt during whose settle abort is raised (0 = never)
    //   bstart_arm attempt whose arm cycle also carries a stray start (0 = never)
    //   rst_arm    attempt during whose wait rst is pulsed (0 = never)
    task automatic campaign(input int fault_at, input int lat, input bit respond,
                            input int abort_arm, input int bstart_arm, input int rst_arm,
                            output int arms, output int cycles, output int arm_cyc, output int err_cyc);
        int done_in;
        int abort_in;
        int rst_in;
        bit stopped;
        bit abort_pend;
        logic [DW+WW-1:0] pt;
        logic [DW-1:0] saved_ds;
        arms       = 0;
        cycles     = 0;
        arm_cyc    = -1;
        err_cyc    = -1;
        done_in    = 0;
        abort_in   = 0;
        rst_in     = 0;
        stopped    = 1'b0;
        abort_pend = 1'b0;
        saved_ds   = delay_start;
        target_fault = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!stopped && cycles < BUDGET) begin
            @(posedge clk); #1;
            cycles++;
            eng_done    = 1'b0;
            start       = 1'b0;
            delay_start = saved_ds;
            if (abort_pend) begin
                abort = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_hit", hit, 0);
                chk("abort_err", err, 0);
                chk("abort_arm", eng_arm, 0);
                stopped = 1'b1;
            end else if (!busy) begin
                if (err) err_cyc = cycles;
                stopped = 1'b1;
            end else if (eng_arm) begin
                arms++;
                if (arm_cyc < 0) arm_cyc = cycles;
                chk("arm_in_plan", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    pt = exp_q.pop_front();
                    chk("arm_delay", eng_delay, pt[DW+WW-1:WW]);
                    chk("arm_width", eng_width, pt[WW-1:0]);
                end
                target_fault = (arms == fault_at);
                if (arms == rst_arm) begin
                    rst_in = 3;
                end else if (respond) begin
                    done_in = (lat > 0) ? lat : int'($urandom_range(1, 6));
                end
                if (arms == bstart_arm) begin
                    start       = 1'b1;
                    delay_start = ~saved_ds;
                end
            end else if (done_in > 0) begin
                done_in--;
                if (done_in == 0) begin
                    eng_done = 1'b1;
                    if (arms == abort_arm) abort_in = 2;
                end
            end else if (abort_in > 0) begin
                abort_in--;
                if (abort_in == 0) begin
                    abort      = 1'b1;
                    abort_pend = 1'b1;
                end
            end else if (rst_in > 0) begin
                rst_in--;
                if (rst_in == 0) begin
                    #1 rst = 1'b1;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_arm", eng_arm, 0);
                    chk("rst_hit", hit, 0);
                    chk("rst_err", err, 0);
                    chk("rst_attempts", attempts, 0);
                    chk("rst_eng_delay", eng_delay, 0);
                    chk("rst_eng_width", eng_width, 0);
                    #1 rst = 1'b0;
                    stopped = 1'b1;
                end
            end
        end
        chk("campaign_ended", stopped, 1);
        target_fault = 1'b0;
        eng_done     = 1'b0;
    endtask

    task automatic run_and_check(input int fault_at, input int lat);
        int arms, cycles, ac, ec, total, exp_arms;
        bit exp_hit;
        logic [DW+WW-1:0] hp;
        total    = plan.size();
        exp_hit  = (fault_at >= 1 && fault_at <= total);
        exp_arms = exp_hit ? fault_at : total;
        campaign(fault_at, lat, 1'b1, 0, 0, 0, arms, cycles, ac, ec);
        chk("arms", arms, exp_arms);
        chk("end_busy", busy, 0);
        chk("end_err", err, 0);
        chk("end_hit", hit, exp_hit);
        chk("end_attempts", attempts, exp_arms);
        chk("unused_points", exp_q.size(), total - exp_arms);
        if (exp_hit) begin
            hp = plan[fault_at-1];
            chk("hit_delay", hit_delay, hp[DW+WW-1:WW]);
            chk("hit_width", hit_width, hp[WW-1:0]);
        end
    endtask

    initial begin
        int arms, cycles, ac, ec, seen, total;
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        eng_done     = 1'b0;
        target_fault = 1'b0;
        set_cfg('0, '0, 16'd0, '0, '0, 16'd0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_arm", eng_arm, 0);
        chk("reset_hit", hit, 0);
        chk("reset_err", err, 0);
        chk("reset_attempts", attempts, 0);
        chk("reset_eng_delay", eng_delay, 0);
        chk("reset_hit_delay", hit_delay, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full 3x2x2 grid, no fault, engine done 4 cycles after each arm.
        set_cfg(32'd100, 32'd10, 16'd3, 16'd5, 16'd1, 16'd2);
        run_and_check(0, 4);

        // Same grid, fault seen on the 5th sample: stops at (110,5).
        set_cfg(32'd100, 32'd10, 16'd3, 16'd5, 16'd1, 16'd2);
        run_and_check(5, 0);

        // Empty delay range: straight to DONE, no arm, hit cleared.
        set_cfg(32'd100, 32'd10, 16'd0, 16'd5, 16'd1, 16'd2);
        campaign(0, 0, 1'b1, 0, 0, 0, arms, cycles, ac, ec);
        chk("empty_arms", arms, 0);
        chk("empty_latency_le2", cycles <= 2, 1);
        chk("empty_busy", busy, 0);
        chk("empty_hit", hit, 0);
        chk("empty_attempts", attempts, 0);

        // Empty width range behaves the same.
        set_cfg(32'd7, 32'd1, 16'd2, 16'd5, 16'd1, 16'd0);
        campaign(0, 0, 1'b1, 0, 0, 0, arms, cycles, ac, ec);
        chk("empty_w_arms", arms, 0);

        // Engine never answers: err exactly TIMEOUT cycles after the arm.
        set_cfg(32'd1, 32'd1, 16'd1, 16'd1, 16'd1, 16'd1);
        campaign(0, 0, 1'b0, 0, 0, 0, arms, cycles, ac, ec);
        chk("timeout_arms", arms, 1);
        chk("timeout_err", err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_attempts", attempts, 0);
        chk("timeout_cycles", ec - ac, TIMEOUT);

        // Abort during settle of the 3rd attempt, then a clean rerun.
        set_cfg(32'd100, 32'd10, 16'd3, 16'd5, 16'd1, 16'd2);
        campaign(0, 0, 1'b1, 3, 0, 0, arms, cycles, ac, ec);
        chk("abort_arms", arms, 3);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (eng_arm) seen++;
        end
        chk("no_arm_after_abort", seen, 0);
        chk("idle_busy_after_abort", busy, 0);
        set_cfg(32'd100, 32'd10, 16'd3, 16'd5, 16'd1, 16'd2);
        run_and_check(0, 0);

        // Asynchronous reset while waiting on the 2nd attempt's engine.
        set_cfg(32'd100, 32'd10, 16'd3, 16'd5, 16'd1, 16'd2);
        campaign(0, 0, 1'b1, 0, 0, 2, arms, cycles, ac, ec);
        chk("rst_campaign_arms", arms, 2);
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);

        // Delay wraps modulo 2^32; a stray start while busy is ignored.
        set_cfg(32'hFFFF_FFF0, 32'h20, 16'd2, 16'd9, 16'd0, 16'd1);
        campaign(0, 0, 1'b1, 0, 1, 0, arms, cycles, ac, ec);
        chk("wrap_arms", arms, plan.size());
        chk("wrap_attempts", attempts, plan.size());
        chk("wrap_busy", busy, 0);
        chk("wrap_hit", hit, 0);

        // Randomized grids and fault positions.
        for (int k = 0; k < 4; k++) begin
            set_cfg($urandom(), $urandom(), 16'($urandom_range(1, 3)),
                    16'($urandom()), 16'($urandom()), 16'($urandom_range(1, 3)));
            total = plan.size();
            run_and_check(int'($urandom_range(0, total + 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
